// File: rtl/text_pkg.sv
// text_pkg: shared constants and state encoding for the text-mode writer.
//   COLS/ROWS     : screen geometry in character cells
//   ADDR_W        : character RAM address width (2^ADDR_W >= COLS*ROWS)
//   BLANK         : fill code for clears and backspace
//   CH_*          : control codes handled by the writer
//   state_e       : writer FSM states
package text_pkg;
  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 6;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS-1);

  typedef enum logic [1:0] {
    FULLCLR = 2'd0,
    IDLE    = 2'd1,
    LINECLR = 2'd2
  } state_e;
endpackage

// File: rtl/text_writer_if.sv
// text_writer_if: character stream in, RAM write port out.
//   in_valid/in_char/in_ready : character handshake (source -> writer)
//   wr_en/wr_addr/wr_data     : character RAM write port (writer -> RAM)
//   modport slave  : the writer side
//   modport master : the source / RAM-observer side
interface text_writer_if;
  import text_pkg::*;

  logic              in_valid;
  logic [7:0]        in_char;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output in_valid, in_char,
                  input  in_ready, wr_en, wr_addr, wr_data);
  modport slave  (input  in_valid, in_char,
                  output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/text_cursor.sv
// text_cursor: column/row cursor with its linear RAM address.
//   clk, rst     : clock, synchronous active-high reset (cursor to 0,0)
//   home_i       : cursor to (0,0)
//   newline_i    : col 0, row+1 wrapping from ROWS-1 to 0
//   cr_i         : col 0
//   dec_i        : col-1, no-op at col 0
//   inc_i        : col+1, saturating at COLS-1
//   col_o, row_o : registered cursor position
//   addr_o       : row*COLS+col
//   row_base_o   : row*COLS
//   at_eol_o     : cursor sits in the last column
module text_cursor
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              home_i,
  input  logic              newline_i,
  input  logic              cr_i,
  input  logic              dec_i,
  input  logic              inc_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] row_base_o,
  output logic              at_eol_o
);
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (newline_i) begin
      col_d = '0;
      row_d = (row_q == ROW_W'(ROWS-1)) ? '0 : row_q + ROW_W'(1);
    end else if (cr_i) begin
      col_d = '0;
    end else if (dec_i && col_q != '0) begin
      col_d = col_q - COL_W'(1);
    end else if (inc_i && col_q != COL_W'(COLS-1)) begin
      col_d = col_q + COL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign row_base_o = ADDR_W'(row_q) * ADDR_W'(COLS);
  assign addr_o     = row_base_o + ADDR_W'(col_q);
  assign at_eol_o   = (col_q == COL_W'(COLS-1));
endmodule

// File: rtl/text_writer.sv
// text_writer: turns a character byte stream into text-mode RAM writes at a
// hardware cursor. Printables are written and advance the cursor; CR, LF, BS
// and FF move the cursor; every newly entered row is blanked (LINECLR) and FF
// or reset blanks the whole screen (FULLCLR). All outputs are registered.
//   clk, rst                 : clock (also the RAM write clock), sync active-high reset
//   io (text_writer_if.slave): in_valid/in_char/in_ready handshake, wr_en/wr_addr/wr_data
//   cur_col, cur_row         : cursor position
//   busy                     : a clear is in progress
// Build option TEXT_WRITER_AUTO_WRAP_EN: a printable in the last column is
// followed by a newline; otherwise the cursor saturates there.
module text_writer
  import text_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  text_writer_if.slave     io,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] cur_row,
  output logic             busy
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  logic              c_home, c_nl, c_cr, c_dec, c_inc;
  logic [ADDR_W-1:0] cur_addr, row_base;
  logic              at_eol;
  logic              accept, clr_wr;

  text_cursor u_cursor (
    .clk        (clk),
    .rst        (rst),
    .home_i     (c_home),
    .newline_i  (c_nl),
    .cr_i       (c_cr),
    .dec_i      (c_dec),
    .inc_i      (c_inc),
    .col_o      (cur_col),
    .row_o      (cur_row),
    .addr_o     (cur_addr),
    .row_base_o (row_base),
    .at_eol_o   (at_eol)
  );

  assign accept = io.in_valid & rdy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    clr_wr    = 1'b0;
    c_home    = 1'b0;
    c_nl      = 1'b0;
    c_cr      = 1'b0;
    c_dec     = 1'b0;
    c_inc     = 1'b0;

    case (state_q)
      FULLCLR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = BLANK;
        clr_wr    = 1'b1;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
          c_home  = 1'b1;
        end
      end

      LINECLR: begin
        // cursor already sits at column 0 of the row being cleared
        wr_en_d   = 1'b1;
        wr_addr_d = row_base + cnt_q;
        wr_data_d = BLANK;
        clr_wr    = 1'b1;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(COLS-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      IDLE: begin
        if (accept) begin
          case (io.in_char)
            CH_CR: c_cr = 1'b1;
            CH_LF: begin
              c_nl    = 1'b1;
              state_d = LINECLR;
              cnt_d   = '0;
            end
            CH_BS: begin
              // blank lands on the cell the cursor moves back onto
              if (cur_col != '0) begin
                c_dec     = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = cur_addr - ADDR_W'(1);
                wr_data_d = BLANK;
              end
            end
            CH_FF: begin
              c_home  = 1'b1;
              state_d = FULLCLR;
              cnt_d   = '0;
            end
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = cur_addr;
              wr_data_d = io.in_char;
              if (!at_eol) begin
                c_inc = 1'b1;
              end else begin
`ifdef TEXT_WRITER_AUTO_WRAP_EN
                c_nl    = 1'b1;
                state_d = LINECLR;
                cnt_d   = '0;
`endif
              end
            end
          endcase
        end
      end

      default: begin
        state_d = FULLCLR;
        cnt_d   = '0;
      end
    endcase

    // ready tracks the state being entered, so it falls with the edge that
    // leaves IDLE; busy also covers the final clear write still on the port
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE) | clr_wr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FULLCLR;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign io.in_ready = rdy_q;
  assign io.wr_en    = wr_en_q;
  assign io.wr_addr  = wr_addr_q;
  assign io.wr_data  = wr_data_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: randomized and directed stimulus for text_writer, checked
// against a screen/cursor reference model that derives the expected ordered
// list of RAM writes and the cursor position from the character rules.
module tb_text_writer;
  import text_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             busy;

  text_writer_if io();

  text_writer dut (
    .clk     (clk),
    .rst     (rst),
    .io      (io),
    .cur_col (cur_col),
    .cur_row (cur_row),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int mcol = 0;
  int mrow = 0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W+7:0] obs_q[$];

  always @(negedge clk) if (io.wr_en) obs_q.push_back({io.wr_addr, io.wr_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic void push_wr(input int a, input logic [7:0] d);
    exp_q.push_back({ADDR_W'(a), d});
  endfunction

  function automatic void push_row();
    for (int i = 0; i < COLS; i++) push_wr(mrow*COLS + i, BLANK);
  endfunction

  function automatic void push_screen();
    for (int i = 0; i < COLS*ROWS; i++) push_wr(i, BLANK);
  endfunction

  function automatic void newline();
    mcol = 0;
    mrow = (mrow + 1) % ROWS;
    push_row();
  endfunction

  function automatic void model(input logic [7:0] c);
    case (c)
      CH_CR: mcol = 0;
      CH_LF: newline();
      CH_BS: if (mcol > 0) begin
        mcol--;
        push_wr(mrow*COLS + mcol, BLANK);
      end
      CH_FF: begin
        mcol = 0;
        mrow = 0;
        push_screen();
      end
      default: begin
        push_wr(mrow*COLS + mcol, c);
        if (mcol < COLS-1) mcol++;
`ifdef TEXT_WRITER_AUTO_WRAP_EN
        else newline();
`endif
      end
    endcase
  endfunction

  // ---------------- drivers / checkers ----------------
  task automatic send(input logic [7:0] c, output int n);
    logic acc;
    acc = 1'b0;
    n = 0;
    io.in_valid = 1'b1;
    io.in_char  = c;
    while (!acc && n < 6000) begin
      acc = io.in_ready;  // value seen by the coming edge
      tick();
      n++;
    end
    io.in_valid = 1'b0;
    if (acc) model(c);
    else chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk("wr", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  task automatic settle();
    int n = 0;
    do begin
      tick();
      n++;
    end while ((busy || !io.in_ready) && n < 6000);
    if (n >= 6000) chk("idle_timeout", 32'(0), 32'(1));
    drain();
    chk("wr_count", 32'(obs_q.size()), 32'(exp_q.size()));
    chk("cursor", 32'({cur_row, cur_col}), 32'({ROW_W'(mrow), COL_W'(mcol)}));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, ffs;
    logic [7:0] c;
    io.in_valid = 1'b0;
    io.in_char  = 8'h00;

    // reset state
    tick(); tick();
    chk("rst_out", 32'({io.wr_en, io.in_ready, busy, io.wr_addr, io.wr_data}),
        32'({3'b001, 13'd0, 8'd0}));
    chk("rst_cur", 32'({cur_row, cur_col}), 32'(0));

    // power-up full clear: 4800 consecutive blank writes
    rst = 1'b0;
    push_screen();
    for (int i = 0; i < COLS*ROWS; i++) begin
      tick();
      chk("fullclr", 32'({io.wr_en, busy, io.wr_addr}), 32'({2'b11, 13'(i)}));
    end
    tick();
    chk("init_done", 32'({io.wr_en, io.in_ready, busy, cur_row, cur_col}), 32'({3'b010, 13'd0}));
    settle();

    // back-to-back printables
    send(8'h48, n);
    chk("h_wait", 32'(n), 32'(1));
    chk("h_wr", 32'({io.wr_en, io.in_ready, io.wr_addr, io.wr_data}), 32'({2'b11, 13'd0, 8'h48}));
    send(8'h69, n);
    chk("i_wait", 32'(n), 32'(1));
    chk("i_wr", 32'({io.wr_en, io.in_ready, io.wr_addr, io.wr_data}), 32'({2'b11, 13'd1, 8'h69}));
    settle();
    chk("pos_2_0", 32'({cur_row, cur_col}), 32'({6'd0, 7'd2}));

    // LF from (5,3) clears row 4
    repeat (3) send(CH_LF, n);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), n);
    settle();
    chk("pos_5_3", 32'({cur_row, cur_col}), 32'({6'd3, 7'd5}));
    send(CH_LF, n);
    chk("lf_busy", 32'({io.in_ready, busy}), 32'({1'b0, 1'b1}));
    k = 0;
    while (!io.in_ready && k < 200) begin
      k++;
      tick();
    end
    chk("lf_low_cycles", 32'(k), 32'(80));
    settle();
    chk("pos_0_4", 32'({cur_row, cur_col}), 32'({6'd4, 7'd0}));
    send(8'h41, n);
    chk("a_wr", 32'({io.wr_en, io.wr_addr, io.wr_data}), 32'({1'b1, 13'd320, 8'h41}));
    settle();

    // BS at column 0, BS mid-row, CR
    send(CH_CR, n);
    settle();
    send(CH_BS, n);
    chk("bs0_nowr", 32'(io.wr_en), 32'(0));
    settle();
    chk("bs0_pos", 32'({cur_row, cur_col}), 32'({6'd4, 7'd0}));
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i), n);
    send(CH_BS, n);
    chk("bs_wr", 32'({io.wr_en, io.wr_addr, io.wr_data}), 32'({1'b1, 13'd329, 8'h20}));
    settle();
    chk("bs_pos", 32'({cur_row, cur_col}), 32'({6'd4, 7'd9}));
    send(CH_CR, n);
    chk("cr_nowr", 32'(io.wr_en), 32'(0));
    settle();

    // last cell of the screen
    repeat (55) send(CH_LF, n);
    for (int i = 0; i < COLS-1; i++) send(8'h41 + 8'(i % 26), n);
    settle();
    chk("pos_79_59", 32'({cur_row, cur_col}), 32'({6'd59, 7'd79}));
    send(8'h5A, n);
    chk("z_wr", 32'({io.wr_en, io.wr_addr, io.wr_data}), 32'({1'b1, 13'd4799, 8'h5A}));
    settle();
`ifdef TEXT_WRITER_AUTO_WRAP_EN
    chk("wrap_pos", 32'({cur_row, cur_col}), 32'(0));
`else
    chk("sat_pos", 32'({cur_row, cur_col}), 32'({6'd59, 7'd79}));
    send(8'h59, n);
    chk("y_wr", 32'({io.wr_en, io.wr_addr, io.wr_data}), 32'({1'b1, 13'd4799, 8'h59}));
    settle();
`endif

    // randomized character stream
    ffs = 0;
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 99));
      if (k < 8)       c = CH_LF;
      else if (k < 16) c = CH_BS;
      else if (k < 24) c = CH_CR;
      else if (k < 25) c = CH_FF;
      else             c = 8'($urandom_range(0, 255));
      if (c == CH_FF) begin
        if (ffs >= 2) c = 8'h2A;
        else ffs++;
      end
      send(c, n);
      if ($urandom_range(0, 3) == 0) tick();
      if (i % 50 == 49) settle();
    end
    settle();

    // FF, then reset mid-clear; a held character waits for the new clear
    send(CH_FF, n);
    k = 0;
    while (!(io.wr_en && io.wr_addr == 13'd1000) && k < 6000) begin
      tick();
      k++;
    end
    if (k >= 6000) chk("ff_reach_1000", 32'(0), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_out", 32'({io.wr_en, io.in_ready, busy, cur_row, cur_col}), 32'({3'b001, 13'd0}));
    drain();
    chk("ff_left", 32'(exp_q.size()), 32'(3799));
    exp_q.delete();
    obs_q.delete();
    mcol = 0;
    mrow = 0;
    push_screen();
    send(8'h51, n);
    chk("held_wait", 32'(n >= 4800), 32'(1));
    chk("q_wr", 32'({io.wr_en, io.wr_addr, io.wr_data}), 32'({1'b1, 13'd0, 8'h51}));
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
